// File: rtl/tt_um_prbs31_checker.sv
// PRBS-31 (x^31+x^28+1) receive checker: fills from the line, verifies 32 predicted
// bits, then free-runs its own predictor and counts bit errors with windowed lock loss.
module tt_um_prbs31_checker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10,
        BAD    = 2'b11
    } state_t;

    logic rx_bit_i, rx_valid_i, clr_cnt_i;
    assign rx_bit_i   = ui_in[0];
    assign rx_valid_i = ui_in[1];
    assign clr_cnt_i  = ui_in[2];

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};

    state_t      state_q, state_d;
    logic [30:0] sr_q, sr_d;
    logic [4:0]  fill_q, fill_d;
    logic [4:0]  match_q, match_d;
    logic [5:0]  win_cnt_q, win_cnt_d;
    logic [3:0]  win_err_q, win_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        err_pulse_q, err_pulse_d;
    logic        locked_q, locked_d;

    logic predict, mismatch;
    assign predict  = sr_q[27] ^ sr_q[30];
    assign mismatch = rx_bit_i ^ predict;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;

        if (state_q == BAD) begin
            state_d = SEARCH;
            fill_d  = 5'd0;
        end else if (rx_valid_i) begin
            case (state_q)
                SEARCH: begin
                    sr_d = {sr_q[29:0], rx_bit_i};
                    if (fill_q == 5'd30) begin
                        fill_d = 5'd0;
                        // An all-zero register is a fixed point of the recurrence; refill.
                        if (sr_d != 31'd0) begin
                            state_d = VERIFY;
                            match_d = 5'd0;
                        end
                    end else begin
                        fill_d = fill_q + 5'd1;
                    end
                end
                VERIFY: begin
                    sr_d = {sr_q[29:0], rx_bit_i};
                    if (mismatch) begin
                        state_d = SEARCH;
                        fill_d  = 5'd0;
                    end else if (match_q == 5'd31) begin
                        state_d   = LOCKED;
                        win_cnt_d = 6'd0;
                        win_err_d = 4'd0;
                    end else begin
                        match_d = match_q + 5'd1;
                    end
                end
                LOCKED: begin
                    // Feed back the prediction so a line error does not poison the register.
                    sr_d        = {sr_q[29:0], predict};
                    err_pulse_d = mismatch;
                    if (mismatch && err_cnt_q != 8'hFF)
                        err_cnt_d = err_cnt_q + 8'd1;
                    if (mismatch && win_err_q == 4'd7) begin
                        state_d   = SEARCH;
                        fill_d    = 5'd0;
                        win_cnt_d = 6'd0;
                        win_err_d = 4'd0;
                    end else if (win_cnt_q == 6'd63) begin
                        win_cnt_d = 6'd0;
                        win_err_d = 4'd0;
                    end else begin
                        win_cnt_d = win_cnt_q + 6'd1;
                        win_err_d = win_err_q + {3'd0, mismatch};
                    end
                end
                default: begin
                    state_d = SEARCH;
                    fill_d  = 5'd0;
                end
            endcase
        end

        if (clr_cnt_i)
            err_cnt_d = 8'd0;
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            sr_q        <= 31'd0;
            fill_q      <= 5'd0;
            match_q     <= 5'd0;
            win_cnt_q   <= 6'd0;
            win_err_q   <= 4'd0;
            err_cnt_q   <= 8'd0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
        end
    end

    assign uo_out  = {4'd0, state_q, err_pulse_q, locked_q};
    assign uio_out = err_cnt_q;
    assign uio_oe  = 8'hFF;

endmodule
